// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: write-back arbiter + register scoreboard.
// Ports: clk, rst_n (sync, active-low); req_valid/req_ready/req_rd/req_val
// (NREQ requesters: 0=ALU 1=LSU 2=MUL/DIV); issue_valid/issue_rd set busy;
// rs1/rs2 -> hazard; busy_vec; reg_we/wb_rd/wb_val register-file write.
// Macro WB_RR_ARB_EN: round-robin arbitration (default fixed priority).
module regfile_wb_arbiter #(
  parameter int XLEN = 32,
  parameter int NREQ = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*5-1:0]    req_rd,
  input  logic [NREQ*XLEN-1:0] req_val,
  input  logic                 issue_valid,
  input  logic [4:0]           issue_rd,
  input  logic [4:0]           rs1,
  input  logic [4:0]           rs2,
  output logic                 hazard,
  output logic [31:0]          busy_vec,
  output logic                 reg_we,
  output logic [4:0]           wb_rd,
  output logic [XLEN-1:0]      wb_val
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IW-1:0]   w_idx;
  logic            w_any;
  logic            w_xfer;
  logic [4:0]      w_rd;
  logic [XLEN-1:0] w_val;
  logic [31:0]     w_busy_nxt;

  logic [31:0]     r_busy;
  logic            r_we;
  logic [4:0]      r_wb_rd;
  logic [XLEN-1:0] r_wb_val;

`ifdef WB_RR_ARB_EN
  logic [IW-1:0] r_ptr;

  // Search order starts at the pointer and wraps.
  always_comb begin
    int j;
    w_idx = '0;
    w_any = 1'b0;
    j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(r_ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!w_any && req_valid[j]) begin
        w_any = 1'b1;
        w_idx = IW'(j);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_xfer) begin
      r_ptr <= (int'(w_idx) == NREQ - 1) ? '0 : w_idx + IW'(1);
    end
  end
`else
  // Lowest index wins.
  always_comb begin
    w_idx = '0;
    w_any = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_any && req_valid[k]) begin
        w_any = 1'b1;
        w_idx = IW'(k);
      end
    end
  end
`endif

  assign w_xfer = rst_n & w_any;
  assign w_rd   = req_rd[int'(w_idx)*5 +: 5];
  assign w_val  = req_val[int'(w_idx)*XLEN +: XLEN];

  always_comb begin
    req_ready = '0;
    if (w_xfer) req_ready[w_idx] = 1'b1;
  end

  // Set after clear: a same-cycle issue is a newer producer.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_xfer) w_busy_nxt[w_rd] = 1'b0;
    if (issue_valid && issue_rd != 5'd0)
      w_busy_nxt[issue_rd] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy   <= '0;
      r_we     <= 1'b0;
      r_wb_rd  <= '0;
      r_wb_val <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      r_we   <= w_xfer && (w_rd != 5'd0);
      if (w_xfer) begin
        r_wb_rd  <= w_rd;
        r_wb_val <= w_val;
      end
    end
  end

  assign hazard = (rs1 != 5'd0 && r_busy[rs1]) ||
                  (rs2 != 5'd0 && r_busy[rs2]);

  assign busy_vec = r_busy;
  assign reg_we   = r_we;
  assign wb_rd    = r_wb_rd;
  assign wb_val   = r_wb_val;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed scenarios plus randomized traffic
// against a queue-level model of arbitration and the scoreboard.
module tb_regfile_wb_arbiter;
  localparam int XLEN = 32;
  localparam int NREQ = 3;
`ifdef WB_RR_ARB_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*5-1:0]    req_rd;
  logic [NREQ*XLEN-1:0] req_val;
  logic                 issue_valid;
  logic [4:0]           issue_rd;
  logic [4:0]           rs1;
  logic [4:0]           rs2;
  logic                 hazard;
  logic [31:0]          busy_vec;
  logic                 reg_we;
  logic [4:0]           wb_rd;
  logic [XLEN-1:0]      wb_val;

  int checks = 0;
  int failures = 0;

  regfile_wb_arbiter #(.XLEN(XLEN), .NREQ(NREQ)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rd(req_rd), .req_val(req_val),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .rs1(rs1), .rs2(rs2), .hazard(hazard),
    .busy_vec(busy_vec), .reg_we(reg_we),
    .wb_rd(wb_rd), .wb_val(wb_val)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [4:0] rd,
                         input logic [XLEN-1:0] v);
    req_rd[i*5 +: 5]       = rd;
    req_val[i*XLEN +: XLEN] = v;
  endtask

  task automatic do_reset();
    req_valid   = '0;
    issue_valid = 1'b0;
    rst_n       = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_req(0, 5'd4, 32'h1234);
    req_valid   = '1;
    issue_valid = 1'b1;
    issue_rd    = 5'd3;
    #1;
    checks++;
    if (req_ready !== 3'b000) begin
      failures++;
      $display("FAIL reset_ready got=%b exp=000", req_ready);
    end
    tick();
    checks++;
    if (reg_we !== 1'b0 || busy_vec !== 32'h0 ||
        wb_rd !== 5'd0 || wb_val !== 32'h0) begin
      failures++;
      $display("FAIL reset_state we=%b busy=%h rd=%0d val=%h exp 0",
               reg_we, busy_vec, wb_rd, wb_val);
    end
    req_valid   = '0;
    issue_valid = 1'b0;
    rst_n       = 1'b1;
    tick();
  endtask

  task automatic test_single();
    set_req(0, 5'd5, 32'hDEADBEEF);
    req_valid = 3'b001;
    #1;
    checks++;
    if (req_ready !== 3'b001) begin
      failures++;
      $display("FAIL single_ready got=%b exp=001", req_ready);
    end
    tick();
    req_valid = '0;
    checks++;
    if (reg_we !== 1'b1 || wb_rd !== 5'd5 || wb_val !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL single_write we=%b rd=%0d val=%h exp 1/5/deadbeef",
               reg_we, wb_rd, wb_val);
    end
    tick();
    checks++;
    if (reg_we !== 1'b0) begin
      failures++;
      $display("FAIL single_we_drop got=%b exp=0", reg_we);
    end
  endtask

  task automatic test_contention();
    int n;
    int e;
    logic [NREQ-1:0] exp_r;
    do_reset();
    set_req(0, 5'd1, 32'h11);
    set_req(1, 5'd2, 32'h22);
    set_req(2, 5'd3, 32'h33);
    req_valid = 3'b111;
    n = RR ? 4 : 3;
    for (int k = 0; k < n; k++) begin
      e = k % NREQ;
      exp_r = '0;
      exp_r[e] = 1'b1;
      #1;
      checks++;
      if (req_ready !== exp_r) begin
        failures++;
        $display("FAIL contend_ready[%0d] got=%b exp=%b", k, req_ready, exp_r);
      end
      tick();
      checks++;
      if (reg_we !== 1'b1 || wb_rd !== 5'(e + 1)) begin
        failures++;
        $display("FAIL contend_write[%0d] we=%b rd=%0d exp rd=%0d",
                 k, reg_we, wb_rd, e + 1);
      end
      if (!RR) req_valid[e] = 1'b0;
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_scoreboard();
    issue_valid = 1'b1;
    issue_rd    = 5'd7;
    tick();
    issue_valid = 1'b0;
    rs1 = 5'd7;
    rs2 = 5'd0;
    #1;
    checks++;
    if (busy_vec[7] !== 1'b1 || hazard !== 1'b1) begin
      failures++;
      $display("FAIL sb_set busy7=%b hazard=%b exp 1/1", busy_vec[7], hazard);
    end
    set_req(0, 5'd7, 32'h77);
    req_valid = 3'b001;
    #1;
    checks++;
    if (req_ready !== 3'b001) begin
      failures++;
      $display("FAIL sb_ready got=%b exp=001", req_ready);
    end
    tick();
    req_valid = '0;
    #1;
    checks++;
    if (busy_vec[7] !== 1'b0 || hazard !== 1'b0 ||
        reg_we !== 1'b1 || wb_rd !== 5'd7) begin
      failures++;
      $display("FAIL sb_clear busy7=%b hazard=%b we=%b rd=%0d exp 0/0/1/7",
               busy_vec[7], hazard, reg_we, wb_rd);
    end
    rs1 = 5'd0;
  endtask

  task automatic test_simultaneous();
    issue_valid = 1'b1;
    issue_rd    = 5'd9;
    set_req(0, 5'd9, 32'h99);
    req_valid = 3'b001;
    #1;
    checks++;
    if (req_ready !== 3'b001) begin
      failures++;
      $display("FAIL simul_ready got=%b exp=001", req_ready);
    end
    tick();
    issue_valid = 1'b0;
    req_valid   = '0;
    checks++;
    if (busy_vec[9] !== 1'b1 || reg_we !== 1'b1) begin
      failures++;
      $display("FAIL simul_set_wins busy9=%b we=%b exp 1/1",
               busy_vec[9], reg_we);
    end
    req_valid = 3'b001;
    tick();
    req_valid = '0;
    checks++;
    if (busy_vec !== 32'h0) begin
      failures++;
      $display("FAIL simul_cleanup busy=%h exp=0", busy_vec);
    end
  endtask

  task automatic test_x0();
    set_req(0, 5'd0, 32'hABC);
    req_valid = 3'b001;
    #1;
    checks++;
    if (req_ready !== 3'b001) begin
      failures++;
      $display("FAIL x0_ready got=%b exp=001", req_ready);
    end
    tick();
    req_valid = '0;
    checks++;
    if (reg_we !== 1'b0) begin
      failures++;
      $display("FAIL x0_we got=%b exp=0", reg_we);
    end
    issue_valid = 1'b1;
    issue_rd    = 5'd0;
    tick();
    issue_valid = 1'b0;
    rs1 = 5'd0;
    rs2 = 5'd0;
    #1;
    checks++;
    if (busy_vec !== 32'h0 || hazard !== 1'b0) begin
      failures++;
      $display("FAIL x0_issue busy=%h hazard=%b exp 0/0", busy_vec, hazard);
    end
  endtask

  task automatic test_random();
    logic            pv[NREQ];
    logic [4:0]      prd[NREQ];
    logic [XLEN-1:0] pval[NREQ];
    logic [31:0]     bm;
    logic [31:0]     bn;
    logic [NREQ-1:0] exp_r;
    logic            exp_h;
    logic            exp_we;
    int ptr_m;
    int g;
    int idx;
    do_reset();
    bm = '0;
    ptr_m = 0;
    for (int i = 0; i < NREQ; i++) begin
      pv[i] = 1'b0;
      prd[i] = '0;
      pval[i] = '0;
    end
    repeat (400) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pv[i] && $urandom_range(0, 1) == 1) begin
          pv[i]   = 1'b1;
          prd[i]  = 5'($urandom_range(0, 31));
          pval[i] = $urandom;
        end
        req_valid[i] = pv[i];
        set_req(i, prd[i], pval[i]);
      end
      issue_valid = ($urandom_range(0, 2) == 0);
      issue_rd    = 5'($urandom_range(0, 31));
      rs1         = 5'($urandom_range(0, 31));
      rs2         = 5'($urandom_range(0, 31));
      g = -1;
      for (int k = 0; k < NREQ; k++) begin
        idx = RR ? (ptr_m + k) % NREQ : k;
        if (g < 0 && pv[idx]) g = idx;
      end
      exp_r = '0;
      if (g >= 0) exp_r[g] = 1'b1;
      exp_h = (rs1 != 0 && bm[rs1]) || (rs2 != 0 && bm[rs2]);
      #1;
      checks++;
      if (req_ready !== exp_r) begin
        failures++;
        $display("FAIL rand_ready got=%b exp=%b", req_ready, exp_r);
      end
      checks++;
      if (hazard !== exp_h) begin
        failures++;
        $display("FAIL rand_hazard got=%b exp=%b", hazard, exp_h);
      end
      bn = bm;
      if (g >= 0) bn[prd[g]] = 1'b0;
      if (issue_valid && issue_rd != 0) bn[issue_rd] = 1'b1;
      exp_we = (g >= 0) && (prd[g] != 0);
      tick();
      checks++;
      if (reg_we !== exp_we) begin
        failures++;
        $display("FAIL rand_we got=%b exp=%b", reg_we, exp_we);
      end
      if (exp_we) begin
        checks++;
        if (wb_rd !== prd[g] || wb_val !== pval[g]) begin
          failures++;
          $display("FAIL rand_data rd=%0d val=%h exp rd=%0d val=%h",
                   wb_rd, wb_val, prd[g], pval[g]);
        end
      end
      checks++;
      if (busy_vec !== bn) begin
        failures++;
        $display("FAIL rand_busy got=%h exp=%h", busy_vec, bn);
      end
      bm = bn;
      if (g >= 0) begin
        pv[g] = 1'b0;
        ptr_m = (g + 1) % NREQ;
      end
    end
    req_valid   = '0;
    issue_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int r = 8; r < 12; r++) begin
      issue_valid = 1'b1;
      issue_rd    = 5'(r);
      tick();
    end
    issue_valid = 1'b0;
    checks++;
    if (busy_vec !== 32'h0000_0F00) begin
      failures++;
      $display("FAIL mid_busy_setup got=%h exp=00000f00", busy_vec);
    end
    set_req(0, 5'd8, 32'h8);
    set_req(1, 5'd9, 32'h9);
    req_valid = 3'b011;
    tick();
    checks++;
    if (reg_we !== 1'b1 || wb_rd !== 5'd8) begin
      failures++;
      $display("FAIL mid_pre_write we=%b rd=%0d exp 1/8", reg_we, wb_rd);
    end
    set_req(0, 5'd10, 32'hA);
    rst_n = 1'b0;
    #1;
    checks++;
    if (req_ready !== 3'b000) begin
      failures++;
      $display("FAIL mid_ready got=%b exp=000", req_ready);
    end
    tick();
    checks++;
    if (reg_we !== 1'b0 || busy_vec !== 32'h0) begin
      failures++;
      $display("FAIL mid_reset we=%b busy=%h exp 0/0", reg_we, busy_vec);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (req_ready !== 3'b001) begin
      failures++;
      $display("FAIL mid_first_grant got=%b exp=001", req_ready);
    end
    tick();
    req_valid = '0;
    checks++;
    if (reg_we !== 1'b1 || wb_rd !== 5'd10 || wb_val !== 32'hA) begin
      failures++;
      $display("FAIL mid_release we=%b rd=%0d val=%h exp 1/10/a",
               reg_we, wb_rd, wb_val);
    end
    tick();
  endtask

  initial begin
    rst_n       = 1'b0;
    req_valid   = '0;
    req_rd      = '0;
    req_val     = '0;
    issue_valid = 1'b0;
    issue_rd    = '0;
    rs1         = '0;
    rs2         = '0;
    tick();
    test_reset();
    test_single();
    test_contention();
    test_scoreboard();
    test_simultaneous();
    test_x0();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
